// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constant tables and GF(2^8) helpers
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, ADD, RND, DONE} state_t;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR = 10;

  localparam byte_t SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);

  byte_t ak [16];
  byte_t mc [16];

  // InvShiftRows folded into the InvSubBytes source index, then key add
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ak[i] = INV_SBOX[st[127 - 8 * ((((i / 4) - (i % 4) + 4) % 4) * 4 + (i % 4)) -: 8]]
              ^ rk[127 - 8 * i -: 8];
    end
  end

  // InvMixColumns per column; bypassed on the final round
  always_comb begin
    nxt = '0;
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gmul(ak[4*c], 8'h0e) ^ gmul(ak[4*c+1], 8'h0b) ^ gmul(ak[4*c+2], 8'h0d) ^ gmul(ak[4*c+3], 8'h09);
      mc[4*c+1] = gmul(ak[4*c], 8'h09) ^ gmul(ak[4*c+1], 8'h0e) ^ gmul(ak[4*c+2], 8'h0b) ^ gmul(ak[4*c+3], 8'h0d);
      mc[4*c+2] = gmul(ak[4*c], 8'h0d) ^ gmul(ak[4*c+1], 8'h09) ^ gmul(ak[4*c+2], 8'h0e) ^ gmul(ak[4*c+3], 8'h0b);
      mc[4*c+3] = gmul(ak[4*c], 8'h0b) ^ gmul(ak[4*c+1], 8'h0d) ^ gmul(ak[4*c+2], 8'h09) ^ gmul(ak[4*c+3], 8'h0e);
    end
    for (int i = 0; i < 16; i++) begin
      nxt[127 - 8 * i -: 8] = last ? ak[i] : mc[i];
    end
  end

endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - iterative AES-128 decryption core with on-the-fly inverse key schedule
module aes_decrypt #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         load,
  input  logic [127:0] ct,
  output logic [127:0] pt,
  output logic         valid,
  output logic         busy
);
  import aes_pkg::*;

  if (NK != 4) begin : g_nk_check
    $error("aes_decrypt: only NK=4 (AES-128) is supported");
  end

  state_t       state;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rnd;

  logic [3:0]   rc_idx;
  byte_t        rc;
  word_t        w0, w1, w2, w3;
  word_t        sw_in, t;
  logic [127:0] rk_fwd, rk_inv;
  logic [127:0] round_out;

  // Shared key-schedule datapath: one SubWord serves both directions, since
  // the inverse step needs SubWord of the recovered w3 (= w3' ^ w2')
  always_comb begin
    rc_idx = 4'd10;
    if (state == KEXP) rc_idx = rnd + 4'd1;
    else if (state == RND && rnd != 4'd0) rc_idx = rnd;
    rc = (rc_idx >= 4'd1 && rc_idx <= 4'd10) ? RCON[rc_idx] : 8'h00;

    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];

    sw_in = (state == KEXP) ? w3 : (w3 ^ w2);
    t     = sub_word(rot_word(sw_in)) ^ {rc, 24'h000000};

    rk_fwd[127:96] = w0 ^ t;
    rk_fwd[95:64]  = w1 ^ rk_fwd[127:96];
    rk_fwd[63:32]  = w2 ^ rk_fwd[95:64];
    rk_fwd[31:0]   = w3 ^ rk_fwd[63:32];

    rk_inv[127:96] = w0 ^ t;
    rk_inv[95:64]  = w1 ^ w0;
    rk_inv[63:32]  = w2 ^ w1;
    rk_inv[31:0]   = w3 ^ w2;
  end

  aes_inv_round u_inv_round (
    .st   (st),
    .rk   (rk),
    .last (rnd == 4'd0),
    .nxt  (round_out)
  );

  // Control FSM with state, round-key and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      rk    <= '0;
      rnd   <= '0;
      pt    <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            st    <= ct;
            rk    <= key;
            rnd   <= 4'd0;
            valid <= 1'b0;
            busy  <= 1'b1;
            state <= KEXP;
          end
        end
        KEXP: begin
          rk  <= rk_fwd;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd9) state <= ADD;
        end
        ADD: begin
          st    <= st ^ rk;
          rk    <= rk_inv;
          rnd   <= 4'd9;
          state <= RND;
        end
        RND: begin
          st <= round_out;
          if (rnd == 4'd0) begin
            pt    <= round_out;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            rk  <= rk_inv;
            rnd <= rnd - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - self-checking bench for aes_decrypt
module tb_aes_decrypt;
  import aes_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [127:0] key;
  logic         load;
  logic [127:0] ct;
  logic [127:0] pt;
  logic         valid;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;
  logic [127:0] exp_q [$];

  aes_decrypt #(.NK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .load  (load),
    .ct    (ct),
    .pt    (pt),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic byte_t mul2(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward AES-128 reference used to produce ciphertexts for loopback vectors
  function automatic logic [127:0] enc_model(input logic [127:0] k, input logic [127:0] p);
    byte_t s [16];
    byte_t t [16];
    byte_t a0, a1, a2, a3;
    logic [31:0] w [4];
    logic [31:0] tmp;
    byte_t rcv;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = p[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
    for (int j = 0; j < 4; j++) w[j] = k[127 - 32 * j -: 32];
    rcv = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp = {SBOX[w[3][23:16]], SBOX[w[3][15:8]], SBOX[w[3][7:0]], SBOX[w[3][31:24]]} ^ {rcv, 24'h0};
      w[0] = w[0] ^ tmp;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rcv = mul2(rcv);
      for (int i = 0; i < 16; i++) t[i] = SBOX[s[(((i / 4) + (i % 4)) % 4) * 4 + (i % 4)]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c+0] = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          t[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // Starts at a negedge: drives a load, optionally pokes an ignored load or
  // pulls reset part-way, and scores latency, busy width and the result
  task automatic run(input string tag, input logic [127:0] k, input logic [127:0] c,
                     input logic [127:0] exp, input int poke_at, input int reset_at);
    int lat;
    int busy_n;
    bit seen;
    key  = k;
    ct   = c;
    load = 1'b1;
    exp_q.push_back(exp);
    lat = -1;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == 1) check({tag, " valid_cleared"}, {127'h0, valid}, 128'h0);
      if (i == poke_at) begin
        key  = ~k;
        ct   = ~c;
        load = 1'b1;
      end
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst_pt"}, pt, 128'h0);
        check({tag, " rst_valid_busy"}, {126'h0, valid, busy}, 128'h0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (busy) busy_n++;
      if (valid) begin
        seen = 1'b1;
        lat = i - 1;
      end
    end
    check_int({tag, " latency"}, lat, 21);
    check_int({tag, " busy_cycles"}, busy_n, 21);
    if (exp_q.size() > 0) check({tag, " pt"}, pt, exp_q.pop_front());
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'hfefd00d583ef87e9b7e6ab3a655f68db;
  localparam logic [127:0] P3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PZ = 128'h140f0f1011b5223d79587717ffd9ec3a;

  initial begin
    logic [127:0] rk_r;
    logic [127:0] rp_r;
    rst_n = 1'b0;
    load  = 1'b0;
    key   = '0;
    ct    = '0;
    repeat (3) @(negedge clk);
    check("reset pt", pt, 128'h0);
    check("reset valid", {127'h0, valid}, 128'h0);
    check("reset busy", {127'h0, busy}, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run("fips_c1", K1, C1, P1, 0, 0);
    run("fips_appb", K2, C2, P2, 0, 0);
    run("loopback", K3, enc_model(K3, P3), P3, 0, 0);

    run("busy_poke", K1, C1, P1, 5, 0);
    run("back_to_back", K2, C2, P2, 0, 0);

    run("mid_reset", K1, C1, P1, 0, 12);
    run("after_reset", K1, C1, P1, 0, 0);

    run("all_zero", 128'h0, 128'h0, PZ, 0, 0);

    for (int n = 0; n < 2; n++) begin
      rk_r = {$urandom, $urandom, $urandom, $urandom};
      rp_r = {$urandom, $urandom, $urandom, $urandom};
      run("random", rk_r, enc_model(rk_r, rp_r), rp_r, 0, 0);
    end

    check_int("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
